// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the fetch-stage state registers.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_RESET_VALUE = '0;

endpackage : cpu_pkg

// File: rtl/en_reg.sv
// Generic W-bit register with load enable and asynchronous active-low reset.
module en_reg #(
  parameter int unsigned W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset overrides everything; otherwise load only when enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RST;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : en_reg

// File: rtl/pc_flag_regs.sv
// Fetch-stage state: program counter and condition-flag registers, each with its own enable.
module pc_flag_regs
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH      = XLEN,
  parameter int unsigned FLAG_WIDTH = 1,
  parameter logic [WIDTH-1:0]      PC_RST   = WIDTH'(PC_RESET_VALUE),
  parameter logic [FLAG_WIDTH-1:0] FLAG_RST = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      pc_d,
  output logic [WIDTH-1:0]      pc_q,
  input  logic                  flag_en,
  input  logic [FLAG_WIDTH-1:0] flag_d,
  output logic [FLAG_WIDTH-1:0] flag_q
);

  if (WIDTH < 1) begin : g_bad_width
    $error("pc_flag_regs: WIDTH must be >= 1");
  end
  if (FLAG_WIDTH < 1) begin : g_bad_flag_width
    $error("pc_flag_regs: FLAG_WIDTH must be >= 1");
  end

  en_reg #(
    .W   (WIDTH),
    .RST (PC_RST)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (start),
    .d     (pc_d),
    .q     (pc_q)
  );

  en_reg #(
    .W   (FLAG_WIDTH),
    .RST (FLAG_RST)
  ) u_flag_reg (
    .clk   (clk),
    .reset (reset),
    .en    (flag_en),
    .d     (flag_d),
    .q     (flag_q)
  );

endmodule : pc_flag_regs

// File: tb/tb_pc_flag_regs.sv
// Directed self-checking bench for pc_flag_regs with hand-computed expectations.
module tb_pc_flag_regs;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] pc_d;
  logic [31:0] pc_q;
  logic        flag_en;
  logic [0:0]  flag_d;
  logic [0:0]  flag_q;

  int unsigned n_checks;
  int unsigned n_pass;

  pc_flag_regs dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pc_d    (pc_d),
    .pc_q    (pc_q),
    .flag_en (flag_en),
    .flag_d  (flag_d),
    .flag_q  (flag_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    start    = 1'b1;
    pc_d     = 32'h0000_0040;
    flag_en  = 1'b1;
    flag_d   = 1'b1;

    // Held in reset with enables high: nothing loads.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_pc", pc_q, 32'h0);
      check("rst_flag", 32'(flag_q), 32'h0);
    end

    // Release between edges with enables low.
    #2;
    start   = 1'b0;
    flag_en = 1'b0;
    reset   = 1'b1;
    step();
    check("rel_pc", pc_q, 32'h0);
    check("rel_flag", 32'(flag_q), 32'h0);

    // PC load sequence, one cycle latency.
    start = 1'b1;
    pc_d  = 32'h4;
    step();
    check("pc_load_4", pc_q, 32'h4);
    pc_d = 32'h8;
    step();
    check("pc_load_8", pc_q, 32'h8);
    pc_d = 32'hC;
    step();
    check("pc_load_c", pc_q, 32'hC);
    start = 1'b0;
    pc_d  = 32'h100;
    step();
    check("pc_hold", pc_q, 32'hC);
    step();
    check("pc_hold2", pc_q, 32'hC);

    // Flag enable behaviour.
    flag_en = 1'b1;
    flag_d  = 1'b1;
    step();
    check("flag_set", 32'(flag_q), 32'h1);
    flag_en = 1'b0;
    flag_d  = 1'b0;
    step();
    check("flag_hold", 32'(flag_q), 32'h1);
    flag_en = 1'b1;
    step();
    check("flag_clr", 32'(flag_q), 32'h0);
    check("flag_pc_untouched", pc_q, 32'hC);

    // Independence of the two enables.
    start   = 1'b1;
    pc_d    = 32'h24;
    flag_en = 1'b0;
    flag_d  = 1'b1;
    step();
    check("ind_pc", pc_q, 32'h24);
    check("ind_flag", 32'(flag_q), 32'h0);
    start   = 1'b0;
    pc_d    = 32'h50;
    flag_en = 1'b1;
    step();
    check("ind2_pc", pc_q, 32'h24);
    check("ind2_flag", 32'(flag_q), 32'h1);

    // Async reset mid-cycle.
    start   = 1'b1;
    pc_d    = 32'hFFFF_FFFC;
    flag_en = 1'b0;
    step();
    check("pre_rst_pc", pc_q, 32'hFFFF_FFFC);
    check("pre_rst_flag", 32'(flag_q), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("async_pc", pc_q, 32'h0);
    check("async_flag", 32'(flag_q), 32'h0);
    pc_d = 32'h8;
    step();
    check("async_edge_pc", pc_q, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check("rel2_pc", pc_q, 32'h0);
    step();
    check("rel2_load_pc", pc_q, 32'h8);
    check("rel2_flag", 32'(flag_q), 32'h0);

    // Boundary values stored verbatim.
    pc_d = 32'hFFFF_FFFF;
    step();
    check("pc_ones", pc_q, 32'hFFFF_FFFF);
    pc_d = 32'h0;
    step();
    check("pc_zero", pc_q, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pc_flag_regs
